// File: rtl/datain_arbiter.sv
// Round-robin, packet-aware arbiter feeding one node's data-input buffer.
// Locks onto a source from head to tail and stops after DEPTH flits.
module datain_arbiter #(
  parameter int NREQ   = 4,
  parameter int FLIT_W = 20,
  parameter int DEPTH  = 128,
  parameter int CW     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*FLIT_W-1:0] flit_in,
  input  logic                   clear,
  output logic [NREQ-1:0]        grant,
  output logic                   out_valid,
  output logic [FLIT_W-1:0]      out_flit,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   locked,
  output logic                   err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_BODY   = 2'b10;
  localparam logic [1:0] T_TAIL   = 2'b11;

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_lock_id;
  logic [CW-1:0]       r_count;
  logic                r_full;
  logic                r_err;
  logic                r_out_valid;
  logic [FLIT_W-1:0]   r_out_flit;

  state_t              w_state_nx;
  logic [PW-1:0]       w_ptr_nx;
  logic [PW-1:0]       w_lock_nx;
  logic                w_err_set;
  logic [PW-1:0]       w_sel;
  logic                w_hit;
  logic                w_acc;
  logic [FLIT_W-1:0]   w_flit;
  logic [1:0]          w_type;
  logic [PW-1:0]       w_sel_inc;
  logic [PW-1:0]       w_lock_inc;

  // Select candidate: locked port only, or round-robin from r_ptr.
  always_comb begin
    int v_idx;
    v_idx = 0;
    w_sel = '0;
    w_hit = 1'b0;
    if (r_state == S_LOCKED) begin
      w_sel = r_lock_id;
      w_hit = req[r_lock_id];
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        v_idx = (int'(r_ptr) + k) % NREQ;
        if (!w_hit && req[v_idx]) begin
          w_hit = 1'b1;
          w_sel = PW'(v_idx);
        end
      end
    end
  end

  assign w_acc  = w_hit && rst && !r_full && !clear;
  assign w_flit = flit_in[w_sel*FLIT_W +: FLIT_W];
  assign w_type = w_flit[1:0];

  assign w_sel_inc  = (w_sel == PW'(NREQ-1)) ? '0 : w_sel + 1'b1;
  assign w_lock_inc = (r_lock_id == PW'(NREQ-1)) ? '0 : r_lock_id + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_lock_id <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_ptr     <= w_ptr_nx;
      r_lock_id <= w_lock_nx;
      r_err     <= r_err | w_err_set;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_lock_nx  = r_lock_id;
    w_err_set  = 1'b0;
    if (w_acc) begin
      if (r_state == S_IDLE) begin
        unique case (w_type)
          T_HEAD: begin
            w_state_nx = S_LOCKED;
            w_lock_nx  = w_sel;
          end
          T_SINGLE: w_ptr_nx = w_sel_inc;
          default: begin
            w_err_set = 1'b1;
            w_ptr_nx  = w_sel_inc;
          end
        endcase
      end else begin
        unique case (w_type)
          T_BODY: ;
          T_TAIL: begin
            w_state_nx = S_IDLE;
            w_ptr_nx   = w_lock_inc;
          end
          T_HEAD: w_err_set = 1'b1;
          default: begin
            w_err_set  = 1'b1;
            w_state_nx = S_IDLE;
            w_ptr_nx   = w_lock_inc;
          end
        endcase
      end
    end
  end

  always_comb begin
    grant = '0;
    if (w_acc) grant = NREQ'(1) << w_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_full      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
    end else begin
      r_out_valid <= w_acc;
      if (w_acc) r_out_flit <= w_flit;
      if (clear) begin
        r_count <= '0;
        r_full  <= 1'b0;
      end else if (w_acc) begin
        r_count <= r_count + 1'b1;
        if (r_count == CW'(DEPTH-1)) r_full <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_flit  = r_out_flit;
  assign count     = r_count;
  assign full      = r_full;
  assign locked    = (r_state == S_LOCKED);
  assign err       = r_err;

endmodule

// File: tb/tb_datain_arbiter.sv
// Directed bench for datain_arbiter: round-robin, locking, stall,
// full/clear boundary, protocol error and async reset.
module tb_datain_arbiter;

  localparam int NREQ = 4;
  localparam int FW   = 20;
  localparam int DEP  = 128;
  localparam int CW   = 8;

  localparam logic [1:0] SG = 2'b00;
  localparam logic [1:0] HD = 2'b01;
  localparam logic [1:0] BD = 2'b10;
  localparam logic [1:0] TL = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [FW-1:0]     f [NREQ];
  logic [NREQ*FW-1:0] flit_in;
  logic              clear;
  logic [NREQ-1:0]   grant;
  logic              out_valid;
  logic [FW-1:0]     out_flit;
  logic [CW-1:0]     count;
  logic              full;
  logic              locked;
  logic              err;

  int n_tot = 0;
  int n_bad = 0;

  assign flit_in = {f[3], f[2], f[1], f[0]};

  always #5 clk = ~clk;

  datain_arbiter #(
    .NREQ(NREQ), .FLIT_W(FW), .DEPTH(DEP), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .flit_in(flit_in),
    .clear(clear), .grant(grant), .out_valid(out_valid),
    .out_flit(out_flit), .count(count), .full(full),
    .locked(locked), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [15:0] p,
                                        input logic [1:0] t);
    return {p, 2'b00, t};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int ng;
  int full_at;

  initial begin
    rst = 1'b0; req = '0; clear = 1'b0;
    for (int i = 0; i < NREQ; i++) f[i] = '0;
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_flit", 32'(out_flit), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_misc", {29'd0, full, locked, err}, 0);
    req = 4'b1111;
    #1;
    chk("rst_hold_grant", 32'(grant), 0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      if (grant != 0) ng++;
      tick();
    end
    chk("idle_grants", 32'(ng), 0);

    // round robin, single flits
    for (int i = 0; i < NREQ; i++) f[i] = mk(16'hA000 + 16'(i), SG);
    req = 4'b1111;
    #1;
    chk("rr_g0", 32'(grant), 32'b0001); tick();
    chk("rr_f0", 32'(out_flit), 32'(mk(16'hA000, SG)));
    chk("rr_v0", 32'(out_valid), 1);
    chk("rr_g1", 32'(grant), 32'b0010); tick();
    chk("rr_f1", 32'(out_flit), 32'(mk(16'hA001, SG)));
    chk("rr_g2", 32'(grant), 32'b0100); tick();
    chk("rr_f2", 32'(out_flit), 32'(mk(16'hA002, SG)));
    chk("rr_g3", 32'(grant), 32'b1000); tick();
    chk("rr_f3", 32'(out_flit), 32'(mk(16'hA003, SG)));
    chk("rr_g4", 32'(grant), 32'b0001); tick();
    chk("rr_f4", 32'(out_flit), 32'(mk(16'hA000, SG)));
    chk("rr_count", 32'(count), 5);

    // packet lock on port 2
    req = 4'b0111;
    f[2] = mk(16'hB000, HD);
    #1;
    chk("pk_g_p1", 32'(grant), 32'b0010); tick();
    chk("pk_g_hd", 32'(grant), 32'b0100);
    chk("pk_lk0", 32'(locked), 0); tick();
    chk("pk_lk1", 32'(locked), 1);
    f[2] = mk(16'hB001, BD);
    #1;
    chk("pk_g_bd", 32'(grant), 32'b0100); tick();
    chk("pk_lk2", 32'(locked), 1);
    f[2] = mk(16'hB002, TL);
    #1;
    chk("pk_g_tl", 32'(grant), 32'b0100); tick();
    chk("pk_lk3", 32'(locked), 0);
    chk("pk_f_tl", 32'(out_flit), 32'(mk(16'hB002, TL)));
    req = 4'b0011;
    #1;
    chk("pk_next", 32'(grant), 32'b0001); tick();
    chk("pk_count", 32'(count), 10);

    // stall inside a lock
    req = 4'b0101;
    f[2] = mk(16'hC000, HD);
    #1;
    chk("st_g_hd", 32'(grant), 32'b0100); tick();
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_g0", 32'(grant), 0); tick();
      chk("st_v0", 32'(out_valid), 0);
    end
    chk("st_hold", 32'(out_flit), 32'(mk(16'hC000, HD)));
    req = 4'b0101;
    f[2] = mk(16'hC001, TL);
    #1;
    chk("st_g_tl", 32'(grant), 32'b0100); tick();
    req = 4'b0001;
    #1;
    chk("st_g_p0", 32'(grant), 32'b0001); tick();
    chk("st_count", 32'(count), 13);
    chk("st_err", 32'(err), 0);

    // full and clear
    req = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cl_count", 32'(count), 0);
    req = 4'b0001;
    ng = 0;
    full_at = 0;
    for (int i = 0; i < 130; i++) begin
      f[0] = mk(16'(i), SG);
      #1;
      if (grant != 0) ng++;
      tick();
      if (full && full_at == 0) full_at = ng;
    end
    chk("fu_grants", 32'(ng), 128);
    chk("fu_at", 32'(full_at), 128);
    chk("fu_count", 32'(count), 128);
    chk("fu_full", 32'(full), 1);
    chk("fu_last", 32'(out_flit), 32'(mk(16'd127, SG)));
    clear = 1'b1;
    #1;
    chk("cl_grant", 32'(grant), 0); tick();
    clear = 1'b0;
    chk("cl_cnt2", 32'(count), 0);
    chk("cl_full", 32'(full), 0);
    #1;
    chk("cl_resume", 32'(grant), 32'b0001); tick();
    chk("cl_cnt3", 32'(count), 1);

    // protocol error: body in idle
    req = 4'b0010;
    f[1] = mk(16'hD000, BD);
    #1;
    chk("pe_g", 32'(grant), 32'b0010); tick();
    chk("pe_v", 32'(out_valid), 1);
    chk("pe_f", 32'(out_flit), 32'(mk(16'hD000, BD)));
    chk("pe_err", 32'(err), 1);

    // full reached mid-packet on port 3
    req = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req = 4'b1000;
    f[3] = mk(16'hE000, HD);
    #1;
    chk("mp_g_hd", 32'(grant), 32'b1000); tick();
    f[3] = mk(16'hE001, BD);
    repeat (DEP - 1) tick();
    chk("mp_full", 32'(full), 1);
    chk("mp_lk", 32'(locked), 1);
    req = 4'b1001;
    f[0] = mk(16'hE100, SG);
    #1;
    chk("mp_g0", 32'(grant), 0); tick();
    chk("mp_v0", 32'(out_valid), 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("mp_g_bd", 32'(grant), 32'b1000); tick();
    f[3] = mk(16'hE002, TL);
    #1;
    chk("mp_g_tl", 32'(grant), 32'b1000); tick();
    chk("mp_f_tl", 32'(out_flit), 32'(mk(16'hE002, TL)));
    chk("mp_lk0", 32'(locked), 0);
    #1;
    chk("mp_g_p0", 32'(grant), 32'b0001); tick();
    chk("mp_err", 32'(err), 1);

    // async reset mid-packet
    req = 4'b0010;
    f[1] = mk(16'hF000, HD);
    tick();
    chk("ar_lk", 32'(locked), 1);
    chk("ar_v", 32'(out_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_v0", 32'(out_valid), 0);
    chk("ar_misc", {29'd0, full, locked, err}, 0);
    chk("ar_cnt", 32'(count), 0);
    chk("ar_g", 32'(grant), 0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/datain_arbiter.md
# datain_arbiter

Round-robin, packet-aware arbiter that shares one node's data-input buffer between NREQ injection sources. It grants one flit per cycle and locks onto a source from head to tail so packets never interleave. It drives the buffer's in_valid/datain pair from a register and stops granting once DEPTH flits have been delivered, which is the point where the buffer wraps and raises its state flag.

## Interface

Parameters:
- NREQ, 4: number of requesting sources (2..8).
- FLIT_W, 20: flit width; payload is [FLIT_W-1:4] and flit type is [1:0].
- DEPTH, 128: flits accepted before `full`; must equal the downstream buffer depth.
- CW, 8: count width, equal to $clog2(DEPTH+1).

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- req, in, NREQ: per-source request; the source holds req and its flit until granted.
- flit_in, in, NREQ*FLIT_W: source i flit at [i*FLIT_W +: FLIT_W].
- clear, in, 1: synchronous clear of count and full.
- grant, out, NREQ: one-hot or zero, combinational; grant[i] high means flit i is accepted this cycle.
- out_valid, out, 1: registered; connects to the buffer's in_valid.
- out_flit, out, FLIT_W: registered; connects to the buffer's datain.
- count, out, CW: flits accepted since reset or clear.
- full, out, 1: count == DEPTH.
- locked, out, 1: a multi-flit packet is in progress.
- err, out, 1: sticky protocol error flag.

## Operation

- Flit type is flit[1:0]: 00 single, 01 head, 10 body, 11 tail.
- State machine:
  - IDLE: grant the first requesting port, searching round-robin from `ptr`.
    - Head → LOCKED on that port (`lock_id`).
    - Single → stay in IDLE; `ptr` ← granted+1 mod NREQ.
    - Body or tail → set err, forward the flit, stay in IDLE, advance `ptr`.
  - LOCKED: grant only `lock_id`, and only when req[lock_id] is high. Other requests wait.
    - Body → stay in LOCKED.
    - Tail → IDLE; `ptr` ← lock_id+1.
    - Head or single → set err, forward the flit. Head keeps the lock; single releases it (→ IDLE).
  - FULL behaviour: when full is high, grant is 0 in every state. State, lock_id and ptr are held.
- Accepting a flit (grant nonzero):
  - out_flit ← the selected flit_in.
  - out_valid ← 1 on the next edge.
  - count ← count+1.
- No grant means out_valid ← 0. out_flit holds its last value.
- full is asserted on the edge where count reaches DEPTH. It is cleared only by clear or rst.
- clear cycle:
  - grant is forced to 0.
  - count ← 0, full ← 0.
  - lock_id, ptr, state and err are unchanged, so a packet interrupted by full resumes on its locked port after clear.
- err is sticky. It is cleared only by rst.

## Timing

- Reset values: out_valid 0, out_flit 0, count 0, full 0, locked 0, err 0, state IDLE, ptr 0, lock_id 0. grant is 0 while rst is low.
- grant is combinational from req, the registered state and full. There is no same-cycle dependency on out_valid.
- Latency: a flit accepted at edge t appears as out_valid/out_flit after edge t, so the buffer samples it at edge t+1.
- Throughput: one flit per cycle. Back-to-back grants to the same or different ports are allowed with no bubble.
- Boundary at count == DEPTH-1:
  - One more accept sets count = DEPTH and full = 1.
  - grant is 0 from the next cycle.
  - count never exceeds DEPTH.
- Asserting rst mid-packet aborts the lock immediately (asynchronously). The buffer sees out_valid drop at once.

## Test plan

- Reset and idle:
  - Stimulus: rst low, then high; req = 0.
  - Required: all outputs 0; grant stays 0 for 10 cycles.
- Round-robin with single flits:
  - Stimulus: req = 4'b1111 held, all flits type 00, payloads 0xA000..0xA003.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001.
  - Required: out_flit follows one cycle later; count = 5 after 5 grants.
- Packet lock:
  - Stimulus: port 2 sends head, body, tail while ports 0 and 1 request continuously.
  - Required: grant = 0100 for three consecutive cycles; locked is high for exactly 2 cycles.
  - Required: the next grant goes to port 3 if it is requesting, otherwise port 0.
- Stall inside a lock:
  - Stimulus: req[2] drops for 3 cycles mid-packet while port 0 requests.
  - Required: grant = 0 during those cycles; out_valid = 0; no port-0 grant until port 2's tail.
- Full and clear:
  - Stimulus: 130 single flits offered.
  - Required: exactly 128 grants; full rises on the edge of the 128th accept; count holds at 128.
  - Required: clear pulse gives count 0, full 0, and granting resumes the cycle after clear.
- Protocol error:
  - Stimulus: a body flit from port 1 in IDLE.
  - Required: the flit is forwarded, err = 1 and stays 1 until rst.
  - Stimulus: full reached mid-packet, then clear.
  - Required: the remaining body and tail flits are granted to the same locked port.
